// File: rtl/fifo_stat.sv
// Synchronous FIFO with first-word-fall-through read, occupancy count, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module fifo_stat #(
    parameter int BITWIDTH   = 8,
    parameter int BITDEPTH   = 2,
    parameter int AFULL_THR  = 3,
    parameter int AEMPTY_THR = 1
) (
    input  logic                clk6x,
    input  logic                reset,
    input  logic                clear_i,
    input  logic [BITWIDTH-1:0] wport_i,
    input  logic                wenq_i,
    output logic [BITWIDTH-1:0] rport_o,
    input  logic                rdeq_i,
    output logic                full_o,
    output logic                empty_o,
    output logic                afull_o,
    output logic                aempty_o,
    output logic [BITDEPTH:0]   count_o,
    output logic                ovf_o,
    output logic                unf_o,
    input  logic                errclr_i
);
    localparam int DEPTH = 2**BITDEPTH;
    localparam logic [BITDEPTH:0] FULL_CNT   = (BITDEPTH+1)'(DEPTH);
    localparam logic [BITDEPTH:0] AFULL_CNT  = (BITDEPTH+1)'(AFULL_THR);
    localparam logic [BITDEPTH:0] AEMPTY_CNT = (BITDEPTH+1)'(AEMPTY_THR);

    logic [BITWIDTH-1:0] mem [DEPTH];
    logic [BITDEPTH-1:0] wr, rd;
    logic                acc_enq, acc_deq, ovf_evt, unf_evt;

    assign full_o   = (count_o == FULL_CNT);
    assign empty_o  = (count_o == '0);
    assign afull_o  = (count_o >= AFULL_CNT);
    assign aempty_o = (count_o <= AEMPTY_CNT);
    assign rport_o  = mem[rd];

    // A full FIFO still takes a write when the head leaves in the same cycle.
    always_comb begin
        acc_enq = 1'b0;
        acc_deq = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (!clear_i) begin
            acc_enq = wenq_i && (!full_o || rdeq_i);
            acc_deq = rdeq_i && !empty_o;
            ovf_evt = wenq_i && full_o && !rdeq_i;
            unf_evt = rdeq_i && empty_o;
        end
    end

    always_ff @(posedge clk6x or posedge reset) begin
        if (reset) begin
            wr      <= '0;
            rd      <= '0;
            count_o <= '0;
        end else if (clear_i) begin
            wr      <= '0;
            rd      <= '0;
            count_o <= '0;
        end else begin
            if (acc_enq) wr <= wr + BITDEPTH'(1);
            if (acc_deq) rd <= rd + BITDEPTH'(1);
            case ({acc_enq, acc_deq})
                2'b10:   count_o <= count_o + (BITDEPTH+1)'(1);
                2'b01:   count_o <= count_o - (BITDEPTH+1)'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    // A fresh error event beats errclr_i in the same cycle.
    always_ff @(posedge clk6x or posedge reset) begin
        if (reset) begin
            ovf_o <= 1'b0;
            unf_o <= 1'b0;
        end else begin
            ovf_o <= ovf_evt || (ovf_o && !errclr_i);
            unf_o <= unf_evt || (unf_o && !errclr_i);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk6x) begin
        if (acc_enq) mem[wr] <= wport_i;
    end
endmodule

// File: tb/tb_fifo_stat.sv
// Bench for fifo_stat: directed vector table, hand-written reset/flush sequences and
// randomized traffic checked against a queue-based model.
module tb_fifo_stat;
    localparam int W = 8, BD = 2, DEPTH = 4, AF = 3, AE = 1;

    logic          clk6x = 1'b0, reset = 1'b1;
    logic          clear_i = 1'b0, wenq_i = 1'b0, rdeq_i = 1'b0, errclr_i = 1'b0;
    logic [W-1:0]  wport_i = '0, rport_o;
    logic          full_o, empty_o, afull_o, aempty_o, ovf_o, unf_o;
    logic [BD:0]   count_o;

    fifo_stat #(.BITWIDTH(W), .BITDEPTH(BD), .AFULL_THR(AF), .AEMPTY_THR(AE)) dut (
        .clk6x(clk6x), .reset(reset), .clear_i(clear_i), .wport_i(wport_i), .wenq_i(wenq_i),
        .rport_o(rport_o), .rdeq_i(rdeq_i), .full_o(full_o), .empty_o(empty_o),
        .afull_o(afull_o), .aempty_o(aempty_o), .count_o(count_o), .ovf_o(ovf_o),
        .unf_o(unf_o), .errclr_i(errclr_i)
    );

    always #5 clk6x = ~clk6x;

    typedef struct {
        bit clr, we, re, ec;
        int wd, cnt, head;
        bit ovf, unf;
    } vec_t;

    vec_t vt[$];
    int   total = 0, bad = 0;

    task automatic add(bit clr, bit we, int wd, bit re, bit ec, int cnt, int head, bit ovf, bit unf);
        vec_t v;
        v.clr = clr; v.we = we; v.wd = wd; v.re = re; v.ec = ec;
        v.cnt = cnt; v.head = head; v.ovf = ovf; v.unf = unf;
        vt.push_back(v);
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Status flags derive from the expected occupancy and the thresholds.
    task automatic check_all(string tag, int cnt, int head, bit ovf, bit unf);
        chk({tag, " count"},  int'(count_o),  cnt);
        chk({tag, " empty"},  int'(empty_o),  int'(cnt == 0));
        chk({tag, " full"},   int'(full_o),   int'(cnt == DEPTH));
        chk({tag, " afull"},  int'(afull_o),  int'(cnt >= AF));
        chk({tag, " aempty"}, int'(aempty_o), int'(cnt <= AE));
        chk({tag, " ovf"},    int'(ovf_o),    int'(ovf));
        chk({tag, " unf"},    int'(unf_o),    int'(unf));
        if (cnt > 0) chk({tag, " head"}, int'(rport_o), head);
    endtask

    task automatic drive(bit clr, bit we, int wd, bit re, bit ec);
        clear_i = clr; wenq_i = we; wport_i = W'(wd); rdeq_i = re; errclr_i = ec;
    endtask

    task automatic tick();
        @(posedge clk6x);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk6x);
        #1 reset = 1'b0;
    endtask

    initial begin
        int q[$];
        bit m_ovf, m_unf;

        // test 1: fill
        add(0,1,'h12,0,0, 1,'h12,0,0);
        add(0,1,'h34,0,0, 2,'h12,0,0);
        add(0,1,'h56,0,0, 3,'h12,0,0);
        add(0,1,'h78,0,0, 4,'h12,0,0);
        // test 2: drain
        add(0,0,0,1,0, 3,'h34,0,0);
        add(0,0,0,1,0, 2,'h56,0,0);
        add(0,0,0,1,0, 1,'h78,0,0);
        add(0,0,0,1,0, 0,0,0,0);
        // test 3: overflow drop and errclr
        add(0,1,'h12,0,0, 1,'h12,0,0);
        add(0,1,'h34,0,0, 2,'h12,0,0);
        add(0,1,'h56,0,0, 3,'h12,0,0);
        add(0,1,'h78,0,0, 4,'h12,0,0);
        add(0,1,'h9A,0,0, 4,'h12,1,0);
        add(0,0,0,0,1,    4,'h12,0,0);
        add(0,0,0,1,0, 3,'h34,0,0);
        add(0,0,0,1,0, 2,'h56,0,0);
        add(0,0,0,1,0, 1,'h78,0,0);
        add(0,0,0,1,0, 0,0,0,0);
        // test 4: streaming at count 2, then enq+deq at full
        add(0,1,'h12,0,0, 1,'h12,0,0);
        add(0,1,'h34,0,0, 2,'h12,0,0);
        add(0,1,'h56,1,0, 2,'h34,0,0);
        add(0,1,'h78,1,0, 2,'h56,0,0);
        add(0,1,'h9A,1,0, 2,'h78,0,0);
        add(0,1,'hBC,1,0, 2,'h9A,0,0);
        add(0,1,'hDE,1,0, 2,'hBC,0,0);
        add(0,1,'hF0,0,0, 3,'hBC,0,0);
        add(0,1,'h11,0,0, 4,'hBC,0,0);
        add(0,1,'h22,1,0, 4,'hDE,0,0);
        add(0,0,0,1,0, 3,'hF0,0,0);
        add(0,0,0,1,0, 2,'h11,0,0);
        add(0,0,0,1,0, 1,'h22,0,0);
        add(0,0,0,1,0, 0,0,0,0);
        // test 5: empty with enq+deq, errclr vs same-cycle event
        add(0,1,'h55,1,0, 1,'h55,0,1);
        add(0,0,0,0,1,    1,'h55,0,0);
        add(0,0,0,1,0,    0,0,0,0);
        add(0,0,0,1,1,    0,0,0,1);
        add(0,0,0,0,1,    0,0,0,0);
        // test 6: flush overrides traffic, sets no flags, keeps sticky flags
        add(0,1,'h01,0,0, 1,'h01,0,0);
        add(0,1,'h02,0,0, 2,'h01,0,0);
        add(0,1,'h03,0,0, 3,'h01,0,0);
        add(1,1,'h44,0,0, 0,0,0,0);
        add(1,0,0,1,0,    0,0,0,0);
        add(0,0,0,1,0,    0,0,0,1);
        add(0,1,'h66,0,0, 1,'h66,0,1);
        add(1,1,'h77,1,0, 0,0,0,1);
        add(0,1,'h88,0,1, 1,'h88,0,0);

        do_reset();
        check_all("reset", 0, 0, 0, 0);

        foreach (vt[i]) begin
            drive(vt[i].clr, vt[i].we, vt[i].wd, vt[i].re, vt[i].ec);
            tick();
            check_all($sformatf("vec%0d", i), vt[i].cnt, vt[i].head, vt[i].ovf, vt[i].unf);
        end

        // async reset mid-fill, checked before any clock edge
        do_reset();
        drive(0, 0, 0, 1, 0); tick();
        drive(0, 1, 'hA1, 0, 0); tick();
        drive(0, 1, 'hA2, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        check_all("prefill", 2, 'hA1, 0, 1);
        #2 reset = 1'b1;
        #1 check_all("async_rst", 0, 0, 0, 0);
        #1 reset = 1'b0;
        tick();
        check_all("post_rst", 0, 0, 0, 0);

        // randomized traffic against a queue model
        q.delete(); m_ovf = 0; m_unf = 0;
        for (int n = 0; n < 3000; n++) begin
            int pw, sz;
            bit clr, we, re, ec, ae, ad, oe, ue;
            int wd;
            pw  = (n / 500) % 2 ? 75 : 35;
            clr = ($urandom_range(0, 99) < 3);
            we  = ($urandom_range(0, 99) < pw);
            re  = ($urandom_range(0, 99) < 50);
            ec  = ($urandom_range(0, 99) < 10);
            wd  = int'($urandom_range(0, 255));
            drive(clr, we, wd, re, ec);
            sz = q.size();
            ae = !clr && we && (sz < DEPTH || re);
            ad = !clr && re && sz > 0;
            oe = !clr && we && sz == DEPTH && !re;
            ue = !clr && re && sz == 0;
            if (clr) q.delete();
            else begin
                if (ad) void'(q.pop_front());
                if (ae) q.push_back(wd);
            end
            m_ovf = oe || (m_ovf && !ec);
            m_unf = ue || (m_unf && !ec);
            tick();
            check_all($sformatf("rnd%0d", n), q.size(), q.size() > 0 ? q[0] : 0, m_ovf, m_unf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
